// File: rtl/piece_board_access.sv
// Collision check and commit of a four-cell tetromino against the board RAM.
// Reads the four cells serially, then writes the piece type into them if the commit is clear.
module piece_board_access #(
  parameter int unsigned BOARD_W   = 10,
  parameter int unsigned BOARD_H   = 20,
  parameter int unsigned POS_BITS  = 8,
  parameter int unsigned TYPE_BITS = 3,
  parameter int unsigned ERR_POS   = 255,
  parameter int unsigned EMPTY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [TYPE_BITS-1:0] req_type,
  input  logic [POS_BITS-1:0]  req_blk_1,
  input  logic [POS_BITS-1:0]  req_blk_2,
  input  logic [POS_BITS-1:0]  req_blk_3,
  input  logic [POS_BITS-1:0]  req_blk_4,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_collide,
  output logic [POS_BITS-1:0]  rd_addr,
  input  logic [TYPE_BITS-1:0] rd_data,
  output logic                 wr_en,
  output logic [POS_BITS-1:0]  wr_addr,
  output logic [TYPE_BITS-1:0] wr_data
);

  localparam int unsigned Cells = BOARD_W * BOARD_H;
  localparam logic [POS_BITS:0]    CellsW = (POS_BITS + 1)'(Cells);
  localparam logic [POS_BITS-1:0]  ErrPos = POS_BITS'(ERR_POS);
  localparam logic [TYPE_BITS-1:0] EmptyT = TYPE_BITS'(EMPTY);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StResp} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 collide_q, collide_d;
  logic [POS_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic                 op_q;
  logic [TYPE_BITS-1:0] type_q;
  logic [POS_BITS-1:0]  blk_q [4];
  logic [POS_BITS-1:0]  blk_in [4];
  logic                 req_ok;
  logic                 accept;
  logic                 occupied;

  assign blk_in[0] = req_blk_1;
  assign blk_in[1] = req_blk_2;
  assign blk_in[2] = req_blk_3;
  assign blk_in[3] = req_blk_4;

  always_comb begin
    req_ok = (req_type != EmptyT);
    for (int i = 0; i < 4; i++) begin
      if (blk_in[i] == ErrPos || {1'b0, blk_in[i]} >= CellsW) req_ok = 1'b0;
    end
  end

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;
  assign occupied  = (rd_data != EmptyT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    collide_d = collide_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          collide_d = ~req_ok;
          cnt_d     = 2'd0;
          if (req_ok) begin
            state_d   = StRead;
            rd_addr_d = blk_in[0];
          end else begin
            state_d = StResp;
          end
        end
      end
      StRead: begin
        // Data for the address issued last cycle arrives now; the first cycle has none yet.
        if (cnt_q != 2'd0) collide_d = collide_q | occupied;
        if (cnt_q == 2'd3) begin
          state_d = StDrain;
        end else begin
          cnt_d     = cnt_q + 2'd1;
          rd_addr_d = blk_q[2'(cnt_q + 2'd1)];
        end
      end
      StDrain: begin
        collide_d = collide_q | occupied;
        cnt_d     = 2'd0;
        state_d   = (op_q && !(collide_q | occupied)) ? StWrite : StResp;
      end
      StWrite: begin
        if (cnt_q == 2'd3) state_d = StResp;
        else               cnt_d   = cnt_q + 2'd1;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      collide_q <= 1'b0;
      rd_addr_q <= '0;
      op_q      <= 1'b0;
      type_q    <= '0;
      for (int i = 0; i < 4; i++) blk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
      rd_addr_q <= rd_addr_d;
      if (accept) begin
        op_q   <= req_op;
        type_q <= req_type;
        for (int i = 0; i < 4; i++) blk_q[i] <= blk_in[i];
      end
    end
  end

  // Gating with rst stops a write or response in the very cycle reset is raised.
  assign wr_en       = (state_q == StWrite) & ~rst;
  assign wr_addr     = wr_en ? blk_q[cnt_q] : '0;
  assign wr_data     = wr_en ? type_q : '0;
  assign rsp_valid   = (state_q == StResp) & ~rst;
  assign rsp_collide = collide_q;
  assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_piece_board_access.sv
// Bench for piece_board_access: board RAM model, directed table, random requests
// against a cell-level reference model, and a reset-during-write sequence.
module tb_piece_board_access;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_op;
  logic [2:0] req_type;
  logic [7:0] req_blk_1, req_blk_2, req_blk_3, req_blk_4;
  logic       rsp_valid, rsp_ready, rsp_collide;
  logic [7:0] rd_addr;
  logic [2:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [2:0] wr_data;

  logic       ram_clear;
  logic [2:0] board  [256];
  logic [2:0] mboard [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piece_board_access dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_type(req_type),
    .req_blk_1(req_blk_1), .req_blk_2(req_blk_2), .req_blk_3(req_blk_3),
    .req_blk_4(req_blk_4),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_collide(rsp_collide),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Board RAM: one-cycle synchronous read, write on the clock edge.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) board[i] <= 3'd0;
      rd_data <= 3'd0;
    end else begin
      rd_data <= board[rd_addr];
      if (wr_en) board[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [2:0] d;
  } wr_t;

  typedef struct {
    bit         op;
    logic [2:0] typ;
    logic [7:0] b0, b1, b2, b3;
    int         hold;
    bit         coll;
    int         lat;
  } vec_t;

  // Drives one request and checks latency, result, read addresses and writes.
  task automatic run_req(input bit op, input logic [2:0] typ, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                         input int hold, input bit use_exp, input bit exp_coll,
                         input int exp_lat);
    logic [7:0] b [4];
    logic [7:0] rd_seen [31];
    wr_t        got [$];
    wr_t        want [$];
    bit         ok, mcoll, ecoll, held_coll, rdy;
    int         mlat, elat, lat, waits;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;

    ok = (typ != 3'd0);
    for (int i = 0; i < 4; i++) if (b[i] >= 8'd200) ok = 0;
    mcoll = !ok;
    if (ok) for (int i = 0; i < 4; i++) if (mboard[b[i]] != 3'd0) mcoll = 1;
    mlat  = !ok ? 1 : ((op && !mcoll) ? 10 : 6);
    ecoll = use_exp ? exp_coll : mcoll;
    elat  = use_exp ? exp_lat : mlat;
    if (ok && op && !mcoll)
      for (int i = 0; i < 4; i++) want.push_back('{cyc: 6 + i, a: b[i], d: typ});

    @(negedge clk);
    check("ready_when_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_type = typ; rsp_ready = 1'b0;
    req_blk_1 = b0; req_blk_2 = b1; req_blk_3 = b2; req_blk_4 = b3;
    rdy = req_ready;
    waits = 0;
    while (!rdy && waits < 20) begin
      @(negedge clk);
      rdy = req_ready;
      waits++;
    end
    if (!rdy) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_type  = 3'($urandom);
    req_blk_1 = 8'($urandom); req_blk_2 = 8'($urandom);
    req_blk_3 = 8'($urandom); req_blk_4 = 8'($urandom);

    lat = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      rd_seen[cyc] = rd_addr;
      if (wr_en) got.push_back('{cyc: cyc, a: wr_addr, d: wr_data});
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
    end
    if (lat == 0) begin
      check("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(lat), 64'(elat));
    check("collide", {63'd0, rsp_collide}, {63'd0, ecoll});
    if (ok && lat >= 4)
      check("rd_addr_seq", {rd_seen[1], rd_seen[2], rd_seen[3], rd_seen[4]}, {b0, b1, b2, b3});
    check("wr_count", 64'(got.size()), 64'(want.size()));
    if (got.size() == want.size())
      foreach (want[i])
        check("wr_beat", {32'(got[i].cyc), 13'd0, got[i].a, got[i].d},
              {32'(want[i].cyc), 13'd0, want[i].a, want[i].d});

    held_coll = rsp_collide;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rsp_hold", {60'd0, rsp_valid, rsp_collide, req_ready, wr_en},
            {60'd0, 1'b1, held_coll, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (ok && op && !mcoll) for (int i = 0; i < 4; i++) mboard[b[i]] = typ;
  endtask

  vec_t vecs [11];
  int   bad;

  initial begin
    rst = 1'b1; ram_clear = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_type = 3'd0; rsp_ready = 1'b0;
    req_blk_1 = 8'd0; req_blk_2 = 8'd0; req_blk_3 = 8'd0; req_blk_4 = 8'd0;
    for (int i = 0; i < 256; i++) mboard[i] = 3'd0;

    vecs[0]  = '{0, 3'd1,   4,   5,  14,  15, 0, 0, 6};
    vecs[1]  = '{1, 3'd2,   4,   5,  14,  15, 0, 0, 10};
    vecs[2]  = '{0, 3'd1,   4,   5,  14,  15, 0, 1, 6};
    vecs[3]  = '{1, 3'd3,  50,  51,  52,  53, 0, 0, 10};
    vecs[4]  = '{1, 3'd2,  44,  45,  52,  54, 5, 1, 6};
    vecs[5]  = '{1, 3'd4,   1,   2, 255,   3, 0, 1, 1};
    vecs[6]  = '{0, 3'd4,   1, 200,   2,   3, 0, 1, 1};
    vecs[7]  = '{1, 3'd0,   1,   2,   3,   6, 0, 1, 1};
    vecs[8]  = '{1, 3'd6, 196, 197, 198, 199, 0, 0, 10};
    vecs[9]  = '{1, 3'd7, 100, 100, 101, 101, 0, 0, 10};
    vecs[10] = '{0, 3'd5,   0,   1,   2,   3, 2, 0, 6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rd_addr, 5'd0, wr_data, wr_addr, 4'd0, req_ready, rsp_valid,
                            rsp_collide, wr_en}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; ram_clear = 1'b0;

    foreach (vecs[i])
      run_req(vecs[i].op, vecs[i].typ, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3,
              vecs[i].hold, 1'b1, vecs[i].coll, vecs[i].lat);

    // Reset during the second write beat: only the first cell may be written.
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_type = 3'd5;
    req_blk_1 = 8'd30; req_blk_2 = 8'd31; req_blk_3 = 8'd32; req_blk_4 = 8'd33;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midwr_first_beat", {52'd0, wr_en, wr_addr, wr_data}, {52'd0, 1'b1, 8'd30, 3'd5});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midwr_gated", {61'd0, wr_en, rsp_valid, req_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("midwr_reset_vals", {rd_addr, 5'd0, wr_data, wr_addr, 4'd0, req_ready, rsp_valid,
                               rsp_collide, wr_en}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mboard[30] = 3'd5;
    @(negedge clk);
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] rb [4];
      for (int i = 0; i < 4; i++)
        rb[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                            : 8'($urandom_range(0, 199));
      run_req(1'($urandom), 3'($urandom_range(0, 7)), rb[0], rb[1], rb[2], rb[3],
              $urandom_range(0, 2), 1'b0, 1'b0, 0);
    end

    bad = 0;
    for (int i = 0; i < 200; i++) if (board[i] !== mboard[i]) bad++;
    check("board_contents", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
